// File: rtl/eth_parser_pkg.sv
// Shared Ethernet parser types: MAC address, per-frame metadata record and
// the default depth of the metadata output queue.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;

  typedef struct packed {
    mac_addr_t   dest_mac;
    mac_addr_t   src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [4:0]  l2_header_len;
    logic        is_ipv4;
    logic        is_ipv6;
    logic        is_arp;
    logic        is_unknown;
  } eth_metadata_t;

  localparam int META_Q_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/meta_fifo.sv
// Generic show-ahead synchronous FIFO. dout always presents the head entry;
// a push while full is accepted only if a pop happens in the same cycle.
module meta_fifo
  import eth_parser_pkg::*;
#(
  parameter int WIDTH = $bits(eth_metadata_t),
  parameter int DEPTH = META_Q_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is reset because the head record must read as all zeros out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/eth_metadata_queue.sv
// Per-frame metadata capture and commit into a show-ahead queue with drop
// accounting. Define METADATA_QUEUE_STATS_EN to build the drop counters.
module eth_metadata_queue
  import eth_parser_pkg::*;
#(
  parameter int DEPTH = META_Q_DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       frame_end,
  input  logic                       frame_err,
  input  logic                       proto_valid,
  input  eth_metadata_t              md_in,
  output eth_metadata_t              m_metadata,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic [CNT_W-1:0]           drop_full_cnt,
  output logic [CNT_W-1:0]           drop_err_cnt
);

  localparam int WIDTH = $bits(eth_metadata_t);

  eth_metadata_t    pending_q, pending_d;
  logic             captured_q, captured_d;
  logic             have_md, capture_en, push, pop, full, empty;
  eth_metadata_t    push_md;
  logic [WIDTH-1:0] fifo_dout;

  // A proto_valid alongside frame_start belongs to the new frame, never the ending one.
  assign have_md    = captured_q || (proto_valid && !frame_start);
  assign capture_en = proto_valid && (frame_start || (!captured_q && !frame_end));
  assign push_md    = captured_q ? pending_q : md_in;
  assign pop        = m_valid && m_ready;
  assign push       = frame_end && !frame_err && have_md && (!full || pop);
  assign m_valid    = !empty;
  assign m_metadata = fifo_dout;

  always_comb begin
    pending_d  = pending_q;
    captured_d = captured_q;
    if (capture_en) begin
      pending_d  = md_in;
      captured_d = 1'b1;
    end else if (frame_start || frame_end) begin
      captured_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      captured_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      captured_q <= captured_d;
    end
  end

  meta_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_md),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

`ifdef METADATA_QUEUE_STATS_EN
  logic             drop_full, drop_err;
  logic [CNT_W-1:0] drop_full_cnt_q, drop_full_cnt_d;
  logic [CNT_W-1:0] drop_err_cnt_q, drop_err_cnt_d;

  assign drop_err  = frame_end && frame_err;
  assign drop_full = frame_end && !frame_err && have_md && full && !pop;

  always_comb begin
    drop_full_cnt_d = drop_full_cnt_q;
    drop_err_cnt_d  = drop_err_cnt_q;
    if (drop_full && (drop_full_cnt_q != '1)) drop_full_cnt_d = drop_full_cnt_q + CNT_W'(1);
    if (drop_err && (drop_err_cnt_q != '1))   drop_err_cnt_d  = drop_err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_full_cnt_q <= '0;
      drop_err_cnt_q  <= '0;
    end else begin
      drop_full_cnt_q <= drop_full_cnt_d;
      drop_err_cnt_q  <= drop_err_cnt_d;
    end
  end

  assign drop_full_cnt = drop_full_cnt_q;
  assign drop_err_cnt  = drop_err_cnt_q;
`else
  assign drop_full_cnt = '0;
  assign drop_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_metadata_queue.sv
// Scoreboard bench for eth_metadata_queue: expected records are queued when a
// committing frame_end is driven and compared whenever the DUT pops.
module tb_eth_metadata_queue;
  import eth_parser_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int FW    = $clog2(DEPTH+1);
`ifdef METADATA_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_start, frame_end, frame_err, proto_valid, m_ready;
  eth_metadata_t    md_in, m_metadata;
  logic             m_valid;
  logic [FW-1:0]    fill_level;
  logic [CNT_W-1:0] drop_full_cnt, drop_err_cnt;

  eth_metadata_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_full = 0;
  int exp_err  = 0;

  eth_metadata_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .frame_err     (frame_err),
    .proto_valid   (proto_valid),
    .md_in         (md_in),
    .m_metadata    (m_metadata),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fill_level    (fill_level),
    .drop_full_cnt (drop_full_cnt),
    .drop_err_cnt  (drop_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
    return STATS ? CNT_W'(v) : '0;
  endfunction

  function automatic eth_metadata_t mk(input int i, input logic [15:0] etype);
    eth_metadata_t m;
    logic [31:0]   iv;
    iv              = 32'(i);
    m               = '0;
    m.dest_mac      = 48'h0200_0000_0000 | 48'(i);
    m.src_mac       = 48'h0a00_0000_1000 + 48'(i * 7);
    m.ethertype     = etype;
    m.vlan_present  = iv[0];
    m.vlan_id       = 12'(i * 3 + 1);
    m.l2_header_len = iv[0] ? 5'd18 : 5'd14;
    m.is_ipv4       = (etype == 16'h0800);
    m.is_ipv6       = (etype == 16'h86DD);
    return m;
  endfunction

  // Scoreboard side: every handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) check("pop_unexpected", 256'(m_valid && m_ready), '0);
      else                check("pop_md", m_metadata, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    frame_err   = 1'b0;
    proto_valid = 1'b0;
  endtask

  task automatic send_frame(input eth_metadata_t a, input bit two, input eth_metadata_t b,
                            input bit err, input bit exp_push);
    idle(); frame_start = 1'b1; tick();
    idle(); proto_valid = 1'b1; md_in = a; tick();
    if (two) begin
      idle(); proto_valid = 1'b1; md_in = b; tick();
    end
    idle(); frame_end = 1'b1; frame_err = err;
    if (exp_push) sb.push_back(a);
    tick();
    idle();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    m_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0 && !m_valid) break;
      tick();
    end
    check({tag, "_sb_empty"}, 256'(sb.size()), '0);
    check({tag, "_fill"}, fill_level, '0);
  endtask

  eth_metadata_t fa, fb, fc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; md_in = '0; idle();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_m_valid", m_valid, '0);
    check("rst_fill", fill_level, '0);
    check("rst_md", m_metadata, '0);
    check("rst_drop_full", drop_full_cnt, '0);
    check("rst_drop_err", drop_err_cnt, '0);

    // Single frame: m_valid rises exactly one cycle after frame_end
    m_ready = 1'b1;
    fa = mk(1, 16'h0800); fa.vlan_id = 12'h064;
    idle(); frame_start = 1'b1; tick();
    idle(); proto_valid = 1'b1; md_in = fa; tick();
    idle(); frame_end = 1'b1; sb.push_back(fa);
    check("lat_not_early", m_valid, '0);
    tick(); idle();
    check("lat_valid", m_valid, 1);
    check("lat_ipv4", m_metadata.is_ipv4, 1);
    check("lat_vlan", m_metadata.vlan_id, 12'h064);
    tick();
    check("lat_gone", m_valid, '0);

    // Six frames while stalled: four queue, two dropped full
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_frame(mk(10 + i, 16'h0800), 1'b0, '0, 1'b0, i < DEPTH);
    exp_full += 2;
    check("stall_fill", fill_level, DEPTH);
    check("stall_drop_full", drop_full_cnt, exp_cnt(exp_full));
    check("stall_head", m_metadata, mk(10, 16'h0800));
    m_ready = 1'b1;
    repeat (DEPTH) tick();
    check("burst_fill", fill_level, '0);
    check("burst_sb", 256'(sb.size()), '0);

    // Second proto_valid in a frame is ignored
    fa = mk(20, 16'h0800); fb = mk(21, 16'h86DD);
    send_frame(fa, 1'b1, fb, 1'b0, 1'b1);
    drain("two_pv", 10);

    // proto_valid only in the frame_end cycle bypasses pending
    fa = mk(22, 16'h0806);
    idle(); frame_start = 1'b1; tick();
    idle(); frame_end = 1'b1; proto_valid = 1'b1; md_in = fa; sb.push_back(fa); tick();
    idle();
    check("bypass_valid", m_valid, 1);
    drain("bypass", 10);

    // frame_end with nothing captured pushes nothing
    idle(); frame_start = 1'b1; tick();
    idle(); frame_end = 1'b1; tick(); idle(); tick();
    check("nocap_valid", m_valid, '0);
    check("nocap_drop_full", drop_full_cnt, exp_cnt(exp_full));

    // Errored frame is dropped and counted
    send_frame(mk(23, 16'h0800), 1'b0, '0, 1'b1, 1'b0);
    exp_err++;
    tick();
    check("err_valid", m_valid, '0);
    check("err_drop_err", drop_err_cnt, exp_cnt(exp_err));

    // Full queue with a pop coincident with frame_end: push accepted
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(mk(30 + i, 16'h0800), 1'b0, '0, 1'b0, 1'b1);
    check("full_fill", fill_level, DEPTH);
    fa = mk(40, 16'h86DD);
    idle(); frame_start = 1'b1; tick();
    idle(); proto_valid = 1'b1; md_in = fa; tick();
    idle(); frame_end = 1'b1; m_ready = 1'b1; sb.push_back(fa); tick();
    idle(); m_ready = 1'b0;
    check("fullpop_fill", fill_level, DEPTH);
    check("fullpop_drop_full", drop_full_cnt, exp_cnt(exp_full));
    check("fullpop_head", m_metadata, mk(31, 16'h0800));
    drain("fullpop", 20);

    // Back-to-back frames sharing frame_end/frame_start cycles
    m_ready = 1'b0;
    fa = mk(50, 16'h0800); fb = mk(51, 16'h86DD); fc = mk(52, 16'h0806);
    idle(); frame_start = 1'b1; proto_valid = 1'b1; md_in = fa; tick();
    idle(); frame_end = 1'b1; frame_start = 1'b1; proto_valid = 1'b1; md_in = fb;
    sb.push_back(fa); tick();
    idle(); frame_end = 1'b1; sb.push_back(fb); tick();
    idle(); frame_end = 1'b1; frame_start = 1'b1; proto_valid = 1'b1; md_in = fc; tick();
    idle(); frame_end = 1'b1; sb.push_back(fc); tick();
    idle();
    check("b2b_fill", fill_level, 3);
    check("b2b_head", m_metadata, fa);

    // Reset mid-frame with three entries queued
    frame_start = 1'b1; proto_valid = 1'b1; md_in = mk(53, 16'h0800); tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_fill", fill_level, '0);
    check("arst_valid", m_valid, '0);
    check("arst_md", m_metadata, '0);
    check("arst_drop_full", drop_full_cnt, '0);
    check("arst_drop_err", drop_err_cnt, '0);
    sb.delete(); exp_full = 0; exp_err = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    idle(); frame_end = 1'b1; tick(); idle(); tick();
    check("post_rst_lost_frame", m_valid, '0);
    send_frame(mk(60, 16'h0800), 1'b0, '0, 1'b0, 1'b1);
    drain("post_rst", 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
